// File: rtl/regfile_pkg.sv
// Shared definitions for the regfile write-side front end.
// Holds the data width, the zero-register test and the writeback entry layout.
package regfile_pkg;

    localparam int DWIDTH    = 16;
    localparam int WB_AWIDTH = 8;
    localparam logic [2:0] R0_MASK = 3'b000;

    // Writeback entry {addr, data} for the default 8-bit register address.
    typedef struct packed {
        logic [WB_AWIDTH-1:0] addr;
        logic [DWIDTH-1:0]    data;
    } wb_entry_t;

    // Any address whose low three bits are zero aliases the hardwired r0.
    function automatic logic is_r0(input logic [2:0] addr_lo);
        return addr_lo == R0_MASK;
    endfunction

endpackage

// File: rtl/regfile_wb_fifo.sv
// Small synchronous FIFO holding queued memory writeback entries.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wb_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                     (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[PW-2:0]];

    // Advance wrap-around pointers; a simultaneous push and pop keeps the fill level.
    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage has no reset; entries are only read once the pointers cover them.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-2:0]] <= din;
    end

endmodule

// File: rtl/regfile_wb.sv
// Write-side front end of regfile_v2: merges ALU and memory writeback into
// the single regfile write port and tracks registers with loads in flight.
// Optional build macro WB_MEM_BYPASS_EN lets a memory result skip the empty
// FIFO and reach the write port one cycle earlier.
module regfile_wb
    import regfile_pkg::*;
#(
    parameter int AWIDTH = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              alu_valid,
    input  logic [AWIDTH-1:0] alu_addr,
    input  logic [DWIDTH-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [AWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_data,
    input  logic              mark_valid,
    input  logic [AWIDTH-1:0] mark_addr,
    input  logic [AWIDTH-1:0] addr_rs,
    input  logic [AWIDTH-1:0] addr_rt,
    output logic              busy_rs,
    output logic              busy_rt,
    output logic [AWIDTH-1:0] addr_rd,
    output logic              req_rd,
    output logic [DWIDTH-1:0] wdata
);

    localparam int EW = AWIDTH + DWIDTH;

    logic [(1<<AWIDTH)-1:0] busy;
    logic [EW-1:0]          fifo_head;
    logic [AWIDTH-1:0]      head_addr;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   alu_take;
    logic                   mem_take;
    logic                   pop;
    logic                   push;
    logic                   bypass;

    assign mem_ready = !clear && !fifo_full;
    assign alu_take  = alu_valid && !is_r0(alu_addr[2:0]);
    assign mem_take  = mem_valid && mem_ready && !is_r0(mem_addr[2:0]);
    assign pop       = !alu_take && !fifo_empty;
    assign head_addr = fifo_head[EW-1:DWIDTH];

`ifdef WB_MEM_BYPASS_EN
    assign bypass = mem_take && fifo_empty && !alu_take;
`else
    assign bypass = 1'b0;
`endif

    assign push = mem_take && !bypass;

    assign busy_rs = busy[addr_rs] && !is_r0(addr_rs[2:0]);
    assign busy_rt = busy[addr_rt] && !is_r0(addr_rt[2:0]);

    wb_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   ({mem_addr, mem_data}),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Output register: ALU wins, then the FIFO head, then a bypassed load; idle holds addr/data.
    always_ff @(posedge clk) begin
        if (clear) begin
            req_rd  <= 1'b0;
            addr_rd <= '0;
            wdata   <= '0;
        end else if (alu_take) begin
            req_rd  <= 1'b1;
            addr_rd <= alu_addr;
            wdata   <= alu_data;
        end else if (pop) begin
            req_rd  <= 1'b1;
            addr_rd <= head_addr;
            wdata   <= fifo_head[DWIDTH-1:0];
        end else if (bypass) begin
            req_rd  <= 1'b1;
            addr_rd <= mem_addr;
            wdata   <= mem_data;
        end else begin
            req_rd  <= 1'b0;
        end
    end

    // Pending-load scoreboard: retire on writeback, then a new mark overrides a same-cycle retire.
    always_ff @(posedge clk) begin
        if (clear) begin
            busy <= '0;
        end else begin
            if (pop)    busy[head_addr] <= 1'b0;
            if (bypass) busy[mem_addr]  <= 1'b0;
            if (mark_valid && !is_r0(mark_addr[2:0])) busy[mark_addr] <= 1'b1;
        end
    end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Write-side front end of regfile_v2.
- Merges writeback results from the single-cycle ALU path and the variable-latency memory/load path into the one regfile write port (addr_rd / req_rd / wdata).
- Buffers memory results in a small FIFO.
- Keeps a per-register pending-load scoreboard that decode queries before issuing.

Parameters:
- AWIDTH, 8, register address width; must match regfile_v2 AWIDTH.
- DEPTH, 4, memory-result FIFO depth (power of two, >= 2).

Ports:
- clk  in  1  clock; all state updates on rising edge
- clear  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU result valid this cycle; never stalled
- alu_addr  in  AWIDTH  ALU destination register
- alu_data  in  16  ALU result
- mem_valid  in  1  memory result offered
- mem_ready  out  1  memory result accepted when mem_valid && mem_ready
- mem_addr  in  AWIDTH  load destination register
- mem_data  in  16  load data
- mark_valid  in  1  decode issued a load; reserve mark_addr
- mark_addr  in  AWIDTH  register reserved by the load
- addr_rs  in  AWIDTH  scoreboard query A
- addr_rt  in  AWIDTH  scoreboard query B
- busy_rs  out  1  register addr_rs has a pending load (combinational)
- busy_rt  out  1  register addr_rt has a pending load (combinational)
- addr_rd  out  AWIDTH  to regfile write address (registered)
- req_rd  out  1  to regfile write enable (registered)
- wdata  out  16  to regfile write data (registered)

Behaviour:
- Zero register: any address with addr[2:0]==0 is r0.
  - Results targeting r0 are accepted but dropped: no req_rd, no FIFO entry.
  - mark_valid to r0 is ignored.
  - busy for r0 always 0.
- Reset (clear=1 at edge):
  - req_rd=0, addr_rd=0, wdata=0.
  - FIFO pointers/count=0.
  - All busy bits=0.
  - mem_ready=0 during the clear cycle, 1 on the first cycle after.
  - Clear mid-drain discards all FIFO contents and pending busy bits.
- mem_ready = !clear && (count != DEPTH). No push-through when full, even if a pop occurs in the same cycle.
- Output register, one arbitration per cycle:
  - ALU valid, non-r0: drive ALU result; FIFO holds.
  - Else FIFO non-empty: pop head, drive it.
  - Else: req_rd=0; addr_rd/wdata hold their previous value.
- Latency:
  - ALU accepted at edge N -> req_rd high during cycle N+1.
  - Memory pushed at edge N -> earliest req_rd in cycle N+2.
- Ordering: memory results leave in acceptance order; ALU may overtake queued loads.
- Scoreboard:
  - busy[mark_addr] set on mark_valid.
  - busy[addr] cleared at the edge where a FIFO entry for that addr is popped to the output.
  - Same-cycle set and clear of the same addr: set wins (newer load).
  - busy_rs / busy_rt are pure lookups of current state. They do not reflect a same-cycle mark; regfile_v2 bypass covers the pop cycle.
- FIFO: wrap-around pointers of log2(DEPTH)+1 bits. Full when MSBs differ and low bits are equal. Simultaneous push and pop keeps count constant.

Optional Feature:
- Macro WB_MEM_BYPASS_EN.
- Defined: when the FIFO is empty, alu_valid=0 (or ALU targets r0), and a non-r0 memory result is accepted, it goes straight to the output register. Latency drops to N+1, no FIFO entry is created, and its busy bit clears that edge.
- Undefined: all memory results pass through the FIFO; minimum latency N+2.

Decomposition:
- Shared package regfile_pkg:
  - DWIDTH=16.
  - R0_MASK=3'b000 and function is_r0(addr).
  - Writeback entry struct/concatenation {addr, data}, also used by regfile_v2 testbenches.
- Sub-module wb_fifo: parameterised DEPTH x (AWIDTH+16) synchronous FIFO with push, pop, full, empty, and head.

Test Plan:
- Reset: clear=1 for 2 cycles -> req_rd=0, addr_rd=0, wdata=0, mem_ready=0; cycle after release mem_ready=1, busy_rs=busy_rt=0.
- ALU write: alu_valid, addr 8'h05, data 16'hBEEF at edge N -> req_rd=1, addr_rd=05, wdata=BEEF in cycle N+1 only.
- Load with scoreboard:
  - mark 8'h09; addr_rs=09 -> busy_rs=1.
  - mem 09/16'h1234 pushed -> req_rd with 1234 at N+2 (N+1 with WB_MEM_BYPASS_EN); busy_rs=0 after that edge.
- Priority/overtake: push mem 03/AAAA, then 04/BBBB, then ALU 06/CCCC held high for 2 cycles -> output order CCCC, CCCC, AAAA, BBBB. Queued memory entries stay in acceptance order.
- Full FIFO: push DEPTH=4 entries under continuous alu_valid -> mem_ready=0; a 5th mem_valid is not accepted. Release ALU -> 4 pops in order; mem_ready re-asserts the cycle after the first pop.
- r0 drop: ALU to 8'h08, mem to 8'h10, mark 8'h00 -> no req_rd, FIFO count stays 0, busy queries for those addresses =0.
